// File: rtl/adderx_share_arb.sv
// Round-robin arbiter granting N_REQ requesters access to one shared adder.
// Three-state flow: grant and capture, add, then hold the response until taken.
module adderx_share_arb #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 2,
  parameter int CHECK = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WIDTH-1:0]     req_a,
  input  logic [N_REQ*WIDTH-1:0]     req_b,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]           rsp_sum,
  output logic                       rsp_ovf,
  output logic                       busy
);

  localparam int IDW = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;

  logic [IDW-1:0]   gnt_idx;
  logic             gnt_any;
  logic             take;
  logic [IDW-1:0]   ptr_nxt;
  logic [WIDTH:0]   sum_full;
  int               j;

  // Rotating priority: scan downward so the lowest offset from ptr wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (req_valid[j]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(j);
      end
    end
  end

  assign take    = (state_q == S_IDLE) && gnt_any && !rst;
  assign ptr_nxt = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    req_ready = '0;
    if (take) req_ready[gnt_idx] = 1'b1;
  end

  assign sum_full = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_id_d    = rsp_id_q;
    unique case (state_q)
      S_IDLE: begin
        if (take) begin
          a_d     = req_a[gnt_idx*WIDTH +: WIDTH];
          b_d     = req_b[gnt_idx*WIDTH +: WIDTH];
          id_d    = gnt_idx;
          ptr_d   = ptr_nxt;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_sum_d   = sum_full[WIDTH-1:0];
        rsp_ovf_d   = (CHECK != 0) ? sum_full[WIDTH] : 1'b0;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_adderx_share_arb.sv
// Bench for adderx_share_arb: two instances (CHECK=1 and CHECK=0) share
// stimulus; directed cases then random traffic against a round-robin model.
module tb_adderx_share_arb;

  localparam int N = 4;
  localparam int W = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic           rsp_ready;

  logic [N-1:0]   rdy1, rdy0;
  logic           rv1, rv0, ovf1, ovf0, busy1, busy0;
  logic [1:0]     id1, id0;
  logic [W-1:0]   sum1, sum0;

  int n_chk  = 0;
  int n_fail = 0;
  int m_ptr  = 0;

  adderx_share_arb #(.N_REQ(N), .WIDTH(W), .CHECK(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a),
    .req_b(req_b), .req_ready(rdy1), .rsp_valid(rv1),
    .rsp_ready(rsp_ready), .rsp_id(id1), .rsp_sum(sum1),
    .rsp_ovf(ovf1), .busy(busy1)
  );

  adderx_share_arb #(.N_REQ(N), .WIDTH(W), .CHECK(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a),
    .req_b(req_b), .req_ready(rdy0), .rsp_valid(rv0),
    .rsp_ready(rsp_ready), .rsp_id(id0), .rsp_sum(sum0),
    .rsp_ovf(ovf0), .busy(busy0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '1;
    #1;
    chk("rst_ready1", 32'(rdy1), 0);
    chk("rst_ready0", 32'(rdy0), 0);
    tick();
    chk("rst_valid", 32'(rv1), 0);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_sum", 32'(sum1), 0);
    chk("rst_ovf", 32'(ovf1), 0);
    chk("rst_id", 32'(id1), 0);
    chk("rst_rdy_hold", 32'(rdy1), 0);
    rst = 1'b0;
    req_valid = '0;
    m_ptr = 0;
  endtask

  // One full transaction; exp_w >= 0 forces a specific expected winner.
  task automatic txn(input logic [N-1:0] v, input logic [N*W-1:0] a,
                     input logic [N*W-1:0] b, input int bp, input int exp_w);
    int w, ea, eb, es, eo;
    req_valid = v;
    req_a = a;
    req_b = b;
    rsp_ready = 1'($urandom_range(1));
    #1;
    w = (exp_w >= 0) ? exp_w : winner(v, m_ptr);
    chk("grant", 32'(rdy1), 32'(1) << w);
    chk("grant_c0", 32'(rdy0), 32'(1) << w);
    chk("idle_busy", 32'(busy1), 0);
    ea = int'(a[w*W +: W]);
    eb = int'(b[w*W +: W]);
    es = (ea + eb) % (1 << W);
    eo = (ea + eb) >= (1 << W) ? 1 : 0;
    tick();
    m_ptr = (w + 1) % N;
    req_valid = 4'($urandom);
    req_a = 8'($urandom);
    req_b = 8'($urandom);
    #1;
    chk("exec_busy", 32'(busy1), 1);
    chk("exec_ready", 32'(rdy1), 0);
    chk("exec_valid", 32'(rv1), 0);
    tick();
    rsp_ready = (bp > 0) ? 1'b0 : 1'b1;
    chk("rsp_valid", 32'(rv1), 1);
    chk("rsp_id", 32'(id1), 32'(w));
    chk("rsp_sum", 32'(sum1), 32'(es));
    chk("rsp_ovf", 32'(ovf1), 32'(eo));
    chk("rsp_sum_c0", 32'(sum0), 32'(es));
    chk("rsp_ovf_c0", 32'(ovf0), 0);
    for (int i = 0; i < bp; i++) begin
      req_valid = 4'($urandom);
      #1;
      chk("bp_ready", 32'(rdy1), 0);
      tick();
      if (i == bp - 1) rsp_ready = 1'b1;
      chk("bp_valid", 32'(rv1), 1);
      chk("bp_busy", 32'(busy1), 1);
      chk("bp_sum", 32'(sum1), 32'(es));
      chk("bp_ovf", 32'(ovf1), 32'(eo));
      chk("bp_id", 32'(id1), 32'(w));
    end
    tick();
    chk("done_valid", 32'(rv1), 0);
    chk("done_busy", 32'(busy1), 0);
    req_valid = '0;
  endtask

  initial begin
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    rst = 1'b0;
    tick();
    do_reset();

    // Single request from requester 2: 1 + 2
    txn(4'b0100, 8'h10, 8'h20, 0, 2);

    // Continuous contention after reset: order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 5; i++)
      txn(4'b1111, 8'($urandom), 8'($urandom), 0, i % 4);

    // Overflow: 3 + 2 on requester 1
    txn(4'b0010, 8'h0C, 8'h08, 0, 1);

    // Backpressure for five cycles
    txn(4'b1000, 8'hC0, 8'h40, 5, 3);

    // Idle with nothing pending: ptr holds, rsp_ready has no effect
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("idle_ready", 32'(rdy1), 0);
      tick();
      chk("idle_busy2", 32'(busy1), 0);
      chk("idle_valid", 32'(rv1), 0);
    end
    txn(4'b1111, 8'h55, 8'hAA, 0, 0);

    // Reset during EXEC aborts the operation
    do_reset();
    req_valid = 4'b0001;
    req_a = 8'h03;
    req_b = 8'h03;
    tick();
    chk("abort_busy", 32'(busy1), 1);
    rst = 1'b1;
    tick();
    chk("abort_valid", 32'(rv1), 0);
    chk("abort_busy0", 32'(busy1), 0);
    tick();
    chk("abort_nrsp", 32'(rv1), 0);
    rst = 1'b0;
    m_ptr = 0;
    txn(4'b1111, 8'h03, 8'h03, 0, 0);

    // Random traffic against the model
    for (int t = 0; t < 60; t++) begin
      logic [N-1:0] v;
      v = 4'($urandom_range(15, 1));
      txn(v, 8'($urandom), 8'($urandom), $urandom_range(3), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
